// File: rtl/ej5_bcd_mul.sv
// ej5_bcd_mul: registered single-digit BCD multiplier.
//
// Multiplies two BCD digits and registers the product as two packed BCD
// digits, one cycle after the operands are sampled. An operand code above 9
// forces a zero product and raises err for that cycle only.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; clears y and err
//   x1    - multiplicand, BCD digit 0-9
//   x2    - multiplier, BCD digit 0-9
//   y     - registered product, y[7:4] tens digit, y[3:0] units digit
//   err   - registered flag: sampled x1 or x2 was greater than 9
module ej5_bcd_mul (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] x1,
  input  logic [3:0] x2,
  output logic [7:0] y,
  output logic       err
);

  logic [6:0]  prod;
  logic [14:0] dabble;
  logic [3:0]  tens;
  logic [3:0]  units;
  logic        err_d;
  logic [7:0]  y_d;
  logic [7:0]  y_q;
  logic        err_q;

  // 7-bit context is enough: legal products never exceed 81.
  assign prod = {3'b000, x1} * {3'b000, x2};

  // Double-dabble: {tens, units, binary}; add 3 to any digit >= 5 before
  // each left shift. Seven shifts move the 7-bit binary fully into BCD.
  always_comb begin
    dabble = {8'h00, prod};
    for (int i = 0; i < 7; i++) begin
      if (dabble[10:7] >= 4'd5) begin
        dabble[10:7] = dabble[10:7] + 4'd3;
      end
      if (dabble[14:11] >= 4'd5) begin
        dabble[14:11] = dabble[14:11] + 4'd3;
      end
      dabble = {dabble[13:0], 1'b0};
    end
    tens  = dabble[14:11];
    units = dabble[10:7];
  end

  always_comb begin
    err_d = (x1 > 4'd9) || (x2 > 4'd9);
    y_d   = err_d ? 8'h00 : {tens, units};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= 8'h00;
      err_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      err_q <= err_d;
    end
  end

  assign y   = y_q;
  assign err = err_q;

endmodule

// File: tb/tb_ej5_bcd_mul.sv
// Directed self-checking bench for ej5_bcd_mul.
module tb_ej5_bcd_mul;

  logic       clk;
  logic       rst_n;
  logic [3:0] x1;
  logic [3:0] x2;
  logic [7:0] y;
  logic       err;

  int tests;
  int fails;

  ej5_bcd_mul u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x1   (x1),
    .x2   (x2),
    .y    (y),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp_y, input logic exp_err, input string tag);
    logic [7:0] prev_y;
    logic       prev_err;
    prev_y   = y;
    prev_err = err;
    x1 = a;
    x2 = b;
    #1;
    // No combinational path: outputs hold until the edge.
    check({tag, "_hold_y"}, y, prev_y);
    check({tag, "_hold_err"}, {7'b0, err}, {7'b0, prev_err});
    step();
    check({tag, "_y"}, y, exp_y);
    check({tag, "_err"}, {7'b0, err}, {7'b0, exp_err});
  endtask

  initial begin
    int p;
    logic [7:0] exp_bcd;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    x1    = 4'd9;
    x2    = 4'd9;

    // Reset held across several edges with 9x9 on the inputs.
    repeat (3) begin
      step();
      check("rst_y", y, 8'h00);
      check("rst_err", {7'b0, err}, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_9x9", y, 8'h81);
    check("post_rst_err", {7'b0, err}, 8'h00);

    apply(4'd7, 4'd8, 8'h56, 1'b0, "7x8");
    apply(4'd5, 4'd2, 8'h10, 1'b0, "5x2");
    apply(4'd3, 4'd3, 8'h09, 1'b0, "3x3");
    apply(4'd0, 4'd9, 8'h00, 1'b0, "0x9");
    apply(4'd9, 4'd9, 8'h81, 1'b0, "9x9");

    // Exhaustive legal sweep, one pair per cycle.
    for (int a = 0; a < 10; a++) begin
      for (int b = 0; b < 10; b++) begin
        x1 = 4'(a);
        x2 = 4'(b);
        step();
        p = a * b;
        exp_bcd = {4'(p / 10), 4'(p % 10)};
        check("sweep_y", y, exp_bcd);
        check("sweep_err", {7'b0, err}, 8'h00);
        if (y[7:4] > 4'd9 || y[3:0] > 4'd9) begin
          check("sweep_nibble_range", y, exp_bcd);
        end
      end
    end

    apply(4'd10, 4'd3, 8'h00, 1'b1, "bad_x1");
    apply(4'd4, 4'd15, 8'h00, 1'b1, "bad_x2");
    apply(4'd4, 4'd6, 8'h24, 1'b0, "recover_4x6");

    // Async reset between edges while streaming 6x7.
    apply(4'd6, 4'd7, 8'h42, 1'b0, "6x7");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_y", y, 8'h00);
    check("async_rst_err", {7'b0, err}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("after_async_6x7", y, 8'h42);
    check("after_async_err", {7'b0, err}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
